// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM encoding, default timeout and timeout read data for bus_arbiter
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int          DEF_TIMEOUT   = 16;
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/bus_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick
//   req[1:0]  requesting masters
//   last      master granted most recently
//   winner    selected master id
//   any       at least one request present
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master single-outstanding bus arbiter with slave timeout
//   clk, rst_n                          clock, async active-low reset
//   mk_req/addr/wdata/byteen            master k request (byteen != 0 means write)
//   mk_gnt                              one-cycle pulse: request accepted
//   mk_rvalid/rdata/err                 completion pulse, held data, timeout flag
//   s_addr/s_wdata/s_byteen             slave request, driven only while BUSY
//   s_rdata, s_ready                    slave response
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_byteen,
    input  logic [31:0] s_rdata,
    input  logic        s_ready
);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              own_q, own_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        byteen_q, byteen_d;
    logic [1:0][31:0]  rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;
    logic              winner, any_req;

    rr_arb2 u_rr (
        .req    ({m1_req, m0_req}),
        .last   (last_q),
        .winner (winner),
        .any    (any_req)
    );

    // last_q resets to 1 so that master 0 wins the first contested grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            own_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
            rdata_q  <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            own_q    <= own_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            byteen_q <= byteen_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        own_d    = own_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        byteen_d = byteen_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (any_req) begin
                state_d  = BUSY;
                cnt_d    = '0;
                own_d    = winner;
                last_d   = winner;
                addr_d   = winner ? m1_addr   : m0_addr;
                wdata_d  = winner ? m1_wdata  : m0_wdata;
                byteen_d = winner ? m1_byteen : m0_byteen;
            end
            // s_ready is checked first so a completion on the timeout edge is not an error
            BUSY: if (s_ready) begin
                state_d        = RESP;
                rdata_d[own_q] = s_rdata;
                err_d[own_q]   = 1'b0;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                state_d        = RESP;
                rdata_d[own_q] = TIMEOUT_RDATA;
                err_d[own_q]   = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // grant is the first BUSY cycle, the only one with the counter still at 0
    always_comb begin
        s_addr    = (state_q == BUSY) ? addr_q   : '0;
        s_wdata   = (state_q == BUSY) ? wdata_q  : '0;
        s_byteen  = (state_q == BUSY) ? byteen_q : '0;
        m0_gnt    = (state_q == BUSY) && (cnt_q == 8'd0) && !own_q;
        m1_gnt    = (state_q == BUSY) && (cnt_q == 8'd0) &&  own_q;
        m0_rvalid = (state_q == RESP) && !own_q;
        m1_rvalid = (state_q == RESP) &&  own_q;
        m0_rdata  = rdata_q[0];
        m1_rdata  = rdata_q[1];
        m0_err    = err_q[0];
        m1_err    = err_q[1];
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus, transaction-level model and per-cycle compare for bus_arbiter
module tb_bus_arbiter;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_byteen;
    logic        s_ready;

    int n_cmp = 0;
    int n_bad = 0;

    bus_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_byteen(s_byteen),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Transaction model: one open transaction, its age in BUSY cycles, and who has priority next
    int          m_age = 0;
    int          m_own = 0;
    int          m_prio = 0;
    bit          m_busy = 0;
    bit          m_resp = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [3:0]  m_byteen = 0;
    logic [31:0] e_rdata [2] = '{0, 0};
    logic [1:0]  e_err = 0;

    function automatic int pick(input logic r0, input logic r1, input int prio);
        return (r0 && r1) ? prio : (r1 ? 1 : 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_resp <= 0; m_age <= 0; m_own <= 0; m_prio <= 0;
            m_addr <= 0; m_wdata <= 0; m_byteen <= 0;
            e_rdata[0] <= 0; e_rdata[1] <= 0; e_err <= 0;
        end else if (m_resp) begin
            m_resp <= 0;
        end else if (m_busy) begin
            if (s_ready || m_age == T - 1) begin
                m_busy <= 0;
                m_resp <= 1;
                e_rdata[m_own] <= s_ready ? s_rdata : 32'h0;
                e_err[m_own] <= !s_ready;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (m0_req || m1_req) begin
            m_own    <= pick(m0_req, m1_req, m_prio);
            m_prio   <= 1 - pick(m0_req, m1_req, m_prio);
            m_busy   <= 1;
            m_age    <= 0;
            m_addr   <= pick(m0_req, m1_req, m_prio) == 1 ? m1_addr   : m0_addr;
            m_wdata  <= pick(m0_req, m1_req, m_prio) == 1 ? m1_wdata  : m0_wdata;
            m_byteen <= pick(m0_req, m1_req, m_prio) == 1 ? m1_byteen : m0_byteen;
        end
    end

    always @(negedge clk) begin
        check("gnt", {30'd0, m1_gnt, m0_gnt},
              {30'd0, m_busy && m_age == 0 && m_own == 1, m_busy && m_age == 0 && m_own == 0});
        check("rvalid", {30'd0, m1_rvalid, m0_rvalid},
              {30'd0, m_resp && m_own == 1, m_resp && m_own == 0});
        check("err", {30'd0, m1_err, m0_err}, {30'd0, e_err});
        check("m0_rdata", m0_rdata, e_rdata[0]);
        check("m1_rdata", m1_rdata, e_rdata[1]);
        check("s_addr", s_addr, m_busy ? m_addr : 32'h0);
        check("s_wdata", s_wdata, m_busy ? m_wdata : 32'h0);
        check("s_byteen", {28'd0, s_byteen}, {28'd0, m_busy ? m_byteen : 4'h0});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    int grants[$];

    initial begin
        rst_n = 1'b1;
        m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_byteen = 0; m1_byteen = 0; s_rdata = 0; s_ready = 0;
        #1 rst_n = 1'b0;
        tick; tick;
        check("rst_byteen", {28'd0, s_byteen}, 32'h0);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'h0);
        rst_n = 1'b1;

        // m0 read, slave answers in the fourth BUSY cycle
        m0_req = 1; m0_addr = 32'h0000_7F04; m0_byteen = 4'h0;
        tick; m0_req = 0;
        check("a_gnt", {30'd0, m1_gnt, m0_gnt}, 32'h1);
        check("a_s_addr", s_addr, 32'h0000_7F04);
        tick;
        check("a_gnt_once", {30'd0, m1_gnt, m0_gnt}, 32'h0);
        tick; tick;
        s_ready = 1; s_rdata = 32'h1234_5678;
        tick; s_ready = 0; s_rdata = 32'hDEAD_BEEF;
        check("a_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'h1);
        check("a_rdata", m0_rdata, 32'h1234_5678);
        check("a_err", {31'd0, m0_err}, 32'h0);
        tick;
        check("a_rvalid_once", {30'd0, m1_rvalid, m0_rvalid}, 32'h0);
        check("a_hold", m0_rdata, 32'h1234_5678);

        // m1 write with no slave answer: timeout after T BUSY cycles
        m1_req = 1; m1_addr = 32'h0000_7F10; m1_wdata = 32'hA5A5_A5A5; m1_byteen = 4'hF;
        tick; m1_req = 0;
        check("b_gnt", {30'd0, m1_gnt, m0_gnt}, 32'h2);
        check("b_s_wdata", s_wdata, 32'hA5A5_A5A5);
        repeat (T - 1) tick;
        check("b_still_busy", {28'd0, s_byteen}, 32'hF);
        check("b_no_rvalid_yet", {30'd0, m1_rvalid, m0_rvalid}, 32'h0);
        tick;
        check("b_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'h2);
        check("b_err", {31'd0, m1_err}, 32'h1);
        check("b_rdata", m1_rdata, 32'h0);
        check("b_m0_hold", m0_rdata, 32'h1234_5678);
        tick;

        // s_ready on the timeout cycle completes normally
        m0_req = 1; m0_addr = 32'h0000_7F20;
        tick; m0_req = 0;
        repeat (T - 1) tick;
        s_ready = 1; s_rdata = 32'hCAFE_F00D;
        tick; s_ready = 0;
        check("c_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'h1);
        check("c_err", {31'd0, m0_err}, 32'h0);
        check("c_rdata", m0_rdata, 32'hCAFE_F00D);
        check("c_m1_err_hold", {31'd0, m1_err}, 32'h1);
        tick;

        // m0 request pulsed only during RESP is ignored
        m1_req = 1; m1_addr = 32'h0000_7F30; m1_byteen = 4'h3;
        tick; m1_req = 0; s_ready = 1; s_rdata = 32'h1111_2222;
        tick; s_ready = 0;
        check("d_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'h2);
        m0_req = 1;
        tick; m0_req = 0;
        check("d_no_gnt", {30'd0, m1_gnt, m0_gnt}, 32'h0);
        tick;
        check("d_no_gnt2", {30'd0, m1_gnt, m0_gnt}, 32'h0);
        check("d_byteen", {28'd0, s_byteen}, 32'h0);

        // request raised and dropped between edges is never seen
        #1 m1_req = 1;
        #2 m1_req = 0;
        tick;
        check("g_glitch_gnt", {30'd0, m1_gnt, m0_gnt}, 32'h0);

        // async reset mid-BUSY, then a lone m1 request wins
        m0_req = 1; m0_addr = 32'h0000_7F40; m0_wdata = 32'h55; m0_byteen = 4'hF;
        tick; m0_req = 0;
        tick;
        check("e_busy", {28'd0, s_byteen}, 32'hF);
        #1 rst_n = 1'b0;
        #1;
        check("e_async_byteen", {28'd0, s_byteen}, 32'h0);
        check("e_async_rdata", m0_rdata, 32'h0);
        check("e_async_addr", s_addr, 32'h0);
        tick; rst_n = 1'b1;
        m1_req = 1;
        tick; m1_req = 0;
        check("e_m1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'h2);
        s_ready = 1;
        tick; s_ready = 0;
        tick;

        // both requesting from reset: grants alternate starting with m0
        rst_n = 1'b0; m0_req = 1; m1_req = 1; s_ready = 1; s_rdata = 32'h0000_600D;
        tick; rst_n = 1'b1;
        repeat (14) begin
            tick;
            check("f_no_double", {31'd0, m0_gnt & m1_gnt}, 32'h0);
            if (m0_gnt) grants.push_back(0);
            if (m1_gnt) grants.push_back(1);
        end
        check("f_grant_count", {31'd0, grants.size() >= 4}, 32'h1);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check("f_order", grants[i], i % 2);
        m0_req = 0; m1_req = 0; s_ready = 0;
        tick; tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
